// File: rtl/hwag_spi_regfile_if.sv
// Byte-level SPI link between spi_slave and the hwag register stage.
// rx_stb qualifies rx_byte and crc_in for exactly one cycle; there is no backpressure,
// and tx_byte is held until the next strobe is consumed.
interface hwag_spi_regfile_if;
  logic       spi_ss;
  logic       rx_stb;
  logic [7:0] rx_byte;
  logic [7:0] crc_in;
  logic [7:0] tx_byte;

  modport master (output spi_ss, output rx_stb, output rx_byte, output crc_in, input tx_byte);
  modport slave  (input spi_ss, input rx_stb, input rx_byte, input crc_in, output tx_byte);
endinterface

// File: rtl/hwag_spi_regfile.sv
// SPI command/register stage: decodes 7-byte frames, checks CRC, commits writes into the
// hwag tunable register bank and returns register contents on the TX path.
module hwag_spi_regfile #(
  parameter int         NREGS  = 8,
  parameter logic [7:0] CMD_WR = 8'h01,
  parameter logic [7:0] CMD_RD = 8'h02
) (
  input  logic                  clk,
  input  logic                  rst,
  hwag_spi_regfile_if.slave     spi,
  output logic [NREGS*32-1:0]   regs_out,
  output logic                  wr_stb,
  output logic [3:0]            wr_addr,
  output logic                  frame_ok,
  output logic [7:0]            err_cnt,
  output logic [2:0]            state_dbg
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RECV   = 3'd1;
  localparam logic [2:0] CHECK  = 3'd2;
  localparam logic [2:0] COMMIT = 3'd3;
  localparam logic [2:0] DRAIN  = 3'd4;

  localparam logic [7:0] NREGS_B = 8'(NREGS);

  logic [2:0]  state;
  logic [2:0]  byte_idx;
  logic [7:0]  cmd_q;
  logic [7:0]  addr_q;
  logic [31:0] data_q;
  logic [31:0] snap;
  logic [31:0] snap_sel;
  logic        crc_ok;
  logic        bad_pend;
  logic [31:0] regs [NREGS];

  function automatic logic [31:0] reg_default(input int k);
    case (k)
      0:       return 32'd50000;
      1:       return 32'd45;
      2:       return 32'd134;
      3:       return 32'd2752;
      4:       return 32'd832;
      default: return 32'd0;
    endcase
  endfunction

  // Out-of-range addresses read back as zero in the snapshot; tx reports 8'hFF for them.
  always_comb begin
    snap_sel = 32'd0;
    for (int k = 0; k < NREGS; k++) begin
      if (spi.rx_byte == 8'(k)) snap_sel = regs[k];
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_out
    assign regs_out[32*g +: 32] = regs[g];
  end

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      byte_idx    <= 3'd0;
      cmd_q       <= 8'd0;
      addr_q      <= 8'd0;
      data_q      <= 32'd0;
      snap        <= 32'd0;
      crc_ok      <= 1'b0;
      bad_pend    <= 1'b0;
      spi.tx_byte <= 8'h00;
      wr_stb      <= 1'b0;
      wr_addr     <= 4'd0;
      frame_ok    <= 1'b0;
      err_cnt     <= 8'd0;
      for (int k = 0; k < NREGS; k++) regs[k] <= reg_default(k);
    end else begin
      wr_stb   <= 1'b0;
      frame_ok <= 1'b0;
      bad_pend <= 1'b0;
      // A rejection decided in CHECK is counted one edge later, even if ss has risen.
      if (bad_pend && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;

      case (state)
        IDLE: begin
          spi.tx_byte <= 8'h00;
          byte_idx    <= 3'd0;
          if (!spi.spi_ss && spi.rx_stb) begin
            cmd_q       <= spi.rx_byte;
            byte_idx    <= 3'd1;
            spi.tx_byte <= 8'hA5;
            state       <= RECV;
          end
        end
        RECV: begin
          if (spi.spi_ss) begin
            state       <= IDLE;
            byte_idx    <= 3'd0;
            spi.tx_byte <= 8'h00;
          end else if (spi.rx_stb) begin
            byte_idx <= byte_idx + 3'd1;
            case (byte_idx)
              3'd1: begin
                addr_q      <= spi.rx_byte;
                snap        <= snap_sel;
                spi.tx_byte <= (spi.rx_byte < NREGS_B) ? snap_sel[7:0] : 8'hFF;
              end
              3'd2: begin data_q[7:0]   <= spi.rx_byte; spi.tx_byte <= snap[15:8];  end
              3'd3: begin data_q[15:8]  <= spi.rx_byte; spi.tx_byte <= snap[23:16]; end
              3'd4: begin data_q[23:16] <= spi.rx_byte; spi.tx_byte <= snap[31:24]; end
              3'd5: begin data_q[31:24] <= spi.rx_byte; spi.tx_byte <= err_cnt;     end
              default: begin
                crc_ok      <= (spi.rx_byte == spi.crc_in);
                spi.tx_byte <= 8'h00;
                byte_idx    <= 3'd0;
                state       <= CHECK;
              end
            endcase
          end
        end
        // CHECK and COMMIT run to completion regardless of ss so a decided frame is not lost.
        CHECK: begin
          if (crc_ok && (cmd_q == CMD_WR || cmd_q == CMD_RD) && addr_q < NREGS_B) begin
            state <= COMMIT;
          end else begin
            state    <= DRAIN;
            bad_pend <= 1'b1;
          end
        end
        COMMIT: begin
          frame_ok <= 1'b1;
          if (cmd_q == CMD_WR) begin
            wr_stb  <= 1'b1;
            wr_addr <= addr_q[3:0];
            for (int k = 0; k < NREGS; k++) begin
              if (addr_q == 8'(k)) regs[k] <= data_q;
            end
          end
          state <= spi.spi_ss ? IDLE : DRAIN;
        end
        DRAIN: begin
          spi.tx_byte <= 8'h00;
          if (spi.spi_ss) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/hwag_spi_regfile.md
Name: hwag_spi_regfile

Overview:
SPI command/register stage sitting between spi_slave and the hwag core. Consumes the 7-byte frame stream (cmd, addr, data[4], crc) byte-by-byte, checks CRC, and commits writes into a bank of 32-bit configuration registers. These registers drive hwag tunables such as the dwell dividend, window filter values and coil offsets. The block also returns register contents on the SPI TX path in the same frame and keeps frame/error statistics.

Parameters:
NREGS, 8, number of 32-bit registers; addresses 0..NREGS-1 valid, max 16
CMD_WR, 8'h01, write command code
CMD_RD, 8'h02, read command code

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock, reset is asynchronous and active-low
spi_ss  in  1  slave select from pin, active-low; high = no frame
rx_stb  in  1  one-cycle pulse: rx_byte holds a new received byte
rx_byte  in  8  received byte (spi_slave bus_out)
crc_in  in  8  running CRC-8 of the frame's bytes before rx_byte, valid at rx_stb
tx_byte  out  8  byte the slave shifts out in the next byte slot
regs_out  out  NREGS*32  flat register bank; reg k = regs_out[32k+31:32k]
wr_stb  out  1  one-cycle pulse when a register is committed
wr_addr  out  4  address of last commit
frame_ok  out  1  one-cycle pulse on any CRC-good, well-formed frame
err_cnt  out  8  saturating count of rejected frames

Behaviour:
- Reset (rst low, async): state IDLE, byte index 0, tx_byte=8'h00, wr_stb=0, wr_addr=0, frame_ok=0, err_cnt=0. Registers: reg0=50000, reg1=45, reg2=134, reg3=2752, reg4=832, all others 0.
- Frame layout: byte0 cmd, byte1 addr, bytes2..5 data LSB first (data={b5,b4,b3,b2}), byte6 crc.
- States: IDLE -> RECV on first rx_stb with spi_ss low. RECV counts bytes 0..6 and latches cmd, addr and data bytes. On byte6, moves to CHECK. CHECK lasts one cycle, then goes to COMMIT if good, else DRAIN. COMMIT lasts one cycle, then DRAIN. DRAIN ignores all rx_stb until spi_ss goes high, then returns to IDLE.
- CRC: sampled at the byte6 strobe. The frame is good when rx_byte == crc_in, cmd is CMD_WR or CMD_RD, and addr < NREGS.
- Timing: byte6 is sampled at edge E. Good/bad is evaluated at edge E+1 (CHECK). Commit happens at edge E+2: reg[addr] is loaded with data only if cmd==CMD_WR, and wr_stb, wr_addr and frame_ok assert for that one cycle. A read frame pulses frame_ok only.
- Bad frame: at edge E+2, err_cnt increments and saturates at 255. No register changes, no wr_stb.
- TX path: tx_byte updates on the clock after each rx_stb.
  - After byte0: 8'hA5.
  - After byte1: addr is snapshotted. tx_byte = reg[addr][7:0], or 8'hFF if addr >= NREGS.
  - After bytes 2..4: tx_byte = next snapshot byte ([15:8], [23:16], [31:24]).
  - After byte5: tx_byte = err_cnt.
  - After byte6 and in IDLE: 8'h00.
- The snapshot is taken after byte1 and is independent of writes committed later in the same frame.
- spi_ss high at any state: return to IDLE within one cycle, clear byte index, tx_byte=0, no commit, err_cnt unchanged.
- spi_ss rising in the same cycle as the byte6 rx_stb: the abort wins and the frame is discarded.
- spi_ss rising during CHECK/COMMIT: the commit already decided still completes, and the state then goes to IDLE.
- rx_stb with spi_ss high: ignored.
- Async reset mid-frame: everything returns to reset values immediately, and the registers reload their defaults.

Test Plan:
- Reset release, no frames -> reg0=50000, reg1=45, reg2=134, reg3=2752, reg4=832, reg5..7=0, tx_byte=0, err_cnt=0.
- Write frame 01,03,78,56,34,12,crc with crc_in matching -> reg3=32'h12345678 two edges after byte6; wr_stb one cycle with wr_addr=3; frame_ok one cycle.
- Read frame 02,01,... -> tx_byte sequence A5,2D,00,00,00,err_cnt,00 (reg1=45); no register change; frame_ok pulse, no wr_stb.
- Write with corrupted crc byte (crc_in=8'h3C, byte6=8'h3D) -> reg unchanged, no wr_stb, err_cnt 0->1. 300 bad frames -> err_cnt=255.
- spi_ss high after byte4 of a write to reg2, then a full valid write to reg2 -> first frame discarded (reg2 stays 134, err_cnt unchanged); second frame commits.
- Write to addr 8 with valid CRC -> tx_byte=FF after byte1, err_cnt increments, no commit. Extra bytes after byte6 with spi_ss low -> ignored until spi_ss high.
